// File: rtl/dlfloat_dot_seq.sv
// DLFloat16 dot-product engine: VLEN operand pairs (A then B) are multiplied and accumulated.
// Latency: B accepted at edge k -> product at k+1 -> accumulator at k+2; the last term raises out_valid after k+2.
// Backpressure: in_ready is high only in OP_A/OP_B; the OUT state holds the result stable until the consumer takes it.
//
// Ports: clk, rst_n (async, active-low), acc_clr (sync abort), in_valid/in_ready/in_data (operand stream),
//        out_valid/out_ready/out_data (result stream, 16 bits, or 8 bits high-byte-first with DLDOT_BYTE_SERIAL_EN).
// Optional feature macro: DLDOT_BYTE_SERIAL_EN.
module dlfloat_dot_seq #(
  parameter int VLEN  = 4,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc_clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef DLDOT_BYTE_SERIAL_EN
  output logic [7:0]  out_data
`else
  output logic [15:0] out_data
`endif
);

  typedef enum logic [2:0] {S_OP_A, S_OP_B, S_MUL, S_ACC, S_OUT} state_t;

  state_t           r_state;
  logic [15:0]      r_a, r_b, r_prod, r_acc, r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
`ifdef DLDOT_BYTE_SERIAL_EN
  logic             r_phase;  // 0: high byte on the port, 1: low byte
`endif

  // ---------------- multiplier ----------------
  logic [9:0]  w_ma, w_mb;
  logic [10:0] w_ph;    // product bits [19:9]; bit 10 is the carry
  logic [7:0]  w_esum;  // ea+eb+carry, exponent is w_esum-31
  logic [15:0] w_mul;

  always_comb begin
    w_ma   = {1'b1, r_a[8:0]};
    w_mb   = {1'b1, r_b[8:0]};
    w_ph   = 11'(({10'd0, w_ma} * {10'd0, w_mb}) >> 9);
    w_esum = {2'b00, r_a[14:9]} + {2'b00, r_b[14:9]} + {7'd0, w_ph[10]};
    w_mul  = 16'h0000;
    if (r_a[14:9] == 6'h3F || r_b[14:9] == 6'h3F)
      w_mul = 16'hFFFF;
    else if (r_a == 16'h0000 || r_b == 16'h0000)
      w_mul = 16'h0000;
    else if (w_esum < 8'd32 || w_esum > 8'd93)  // exponent outside 1..62
      w_mul = 16'hFFFF;
    else
      w_mul = {r_a[15] ^ r_b[15], w_esum[5:0] - 6'd31, w_ph[10] ? w_ph[9:1] : w_ph[8:0]};
  end

  // ---------------- adder (acc + prod) ----------------
  logic        w_acc_big;
  logic [15:0] w_big, w_sml, w_add;
  logic [5:0]  w_d;
  logic [9:0]  w_ms;
  logic [10:0] w_sum;
  logic [3:0]  w_pos, w_shift;
  logic [8:0]  w_norm;

  always_comb begin
    // Magnitude order of {exp,mant} equals order of the encoded bits [14:0].
    w_acc_big = (r_acc[14:0] >= r_prod[14:0]);
    w_big     = w_acc_big ? r_acc : r_prod;
    w_sml     = w_acc_big ? r_prod : r_acc;
    w_d       = w_big[14:9] - w_sml[14:9];
    w_ms      = {1'b1, w_sml[8:0]} >> w_d;
    if (w_big[15] == w_sml[15])
      w_sum = {2'b01, w_big[8:0]} + {1'b0, w_ms};
    else
      w_sum = {2'b01, w_big[8:0]} - {1'b0, w_ms};
    w_pos = 4'd0;
    for (int i = 0; i < 10; i++)
      if (w_sum[i]) w_pos = 4'(i);
    w_shift = 4'd9 - w_pos;
    w_norm  = 9'(w_sum[9:0] << w_shift);
    w_add   = 16'h0000;
    if (r_acc == 16'hFFFF || r_prod == 16'hFFFF)
      w_add = 16'hFFFF;
    else if (r_acc == 16'h0000)
      w_add = r_prod;
    else if (r_prod == 16'h0000)
      w_add = r_acc;
    else if (w_sum == 11'd0)
      w_add = 16'h0000;
    else if (w_sum[10]) begin
      // carry out: shift right one, exponent up; saturate to the special value
      if (w_big[14:9] >= 6'd62) w_add = 16'hFFFF;
      else                      w_add = {w_big[15], w_big[14:9] + 6'd1, w_sum[9:1]};
    end else if ({2'b00, w_shift} >= w_big[14:9])
      w_add = 16'h0000;  // renormalisation would underflow the exponent: flush to zero
    else
      w_add = {w_big[15], w_big[14:9] - {2'b00, w_shift}, w_norm};
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_OP_A;
      r_a         <= 16'h0000;
      r_b         <= 16'h0000;
      r_prod      <= 16'h0000;
      r_acc       <= 16'h0000;
      r_res       <= 16'h0000;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
`ifdef DLDOT_BYTE_SERIAL_EN
      r_phase     <= 1'b0;
`endif
    end else if (acc_clr) begin
      r_state     <= S_OP_A;
      r_acc       <= 16'h0000;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
`ifdef DLDOT_BYTE_SERIAL_EN
      r_phase     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_OP_A: if (in_valid) begin
          r_a     <= in_data;
          r_state <= S_OP_B;
        end
        S_OP_B: if (in_valid) begin
          r_b     <= in_data;
          r_state <= S_MUL;
        end
        S_MUL: begin
          r_prod  <= w_mul;
          r_state <= S_ACC;
        end
        S_ACC: begin
          r_acc <= w_add;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(VLEN - 1)) begin
            r_res       <= w_add;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_state <= S_OP_A;
          end
        end
        S_OUT: if (out_ready) begin
`ifdef DLDOT_BYTE_SERIAL_EN
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_phase     <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc       <= 16'h0000;
            r_cnt       <= '0;
            r_state     <= S_OP_A;
          end
`else
          r_out_valid <= 1'b0;
          r_acc       <= 16'h0000;
          r_cnt       <= '0;
          r_state     <= S_OP_A;
`endif
        end
        default: r_state <= S_OP_A;
      endcase
    end
  end

  assign in_ready  = (r_state == S_OP_A) || (r_state == S_OP_B);
  assign out_valid = r_out_valid;
`ifdef DLDOT_BYTE_SERIAL_EN
  assign out_data  = r_phase ? r_res[7:0] : r_res[15:8];
`else
  assign out_data  = r_res;
`endif

endmodule

// File: tb/tb_dlfloat_dot_seq.sv
// Bench for dlfloat_dot_seq: three instances (VLEN 4, 1, 2) driven by a vector table, hand sequences and random vectors.
// Latency: results are collected through a bounded valid/ready handshake.
// Backpressure: out_ready is held low in one sequence to check stall stability.
module tb_dlfloat_dot_seq;

`ifdef DLDOT_BYTE_SERIAL_EN
  localparam int OW = 8;
`else
  localparam int OW = 16;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          acc_clr   [3];
  logic          in_valid  [3];
  logic          in_ready  [3];
  logic [15:0]   in_data   [3];
  logic          out_valid [3];
  logic          out_ready [3];
  logic [OW-1:0] out_data  [3];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gu
      dlfloat_dot_seq #(.VLEN(g == 0 ? 4 : (g == 1 ? 1 : 2)), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .acc_clr(acc_clr[g]),
        .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
        .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g])
      );
    end
  endgenerate

  int checks = 0;
  int failures = 0;

  function automatic int vlen_of(int u);
    return (u == 0) ? 4 : ((u == 1) ? 1 : 2);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------- reference model: plain integer arithmetic on the format rules ----------
  function automatic logic [15:0] m_mul(logic [15:0] a, logic [15:0] b);
    int p, e, m;
    if (a[14:9] == 6'd63 || b[14:9] == 6'd63) return 16'hFFFF;
    if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
    p = (512 + int'(a[8:0])) * (512 + int'(b[8:0]));
    e = int'(a[14:9]) + int'(b[14:9]) - 31;
    if (p >= (1 << 19)) begin e = e + 1; m = (p / 1024) % 512; end
    else m = (p / 512) % 512;
    if (e > 62 || e < 1) return 16'hFFFF;
    return {a[15] ^ b[15], 6'(e), 9'(m)};
  endfunction

  function automatic logic [15:0] m_add(logic [15:0] x, logic [15:0] y);
    logic [15:0] big, sml;
    int vb, vs, d, r, e;
    if (x == 16'hFFFF || y == 16'hFFFF) return 16'hFFFF;
    if (x == 16'h0000) return y;
    if (y == 16'h0000) return x;
    if (int'(x[14:9]) * 512 + int'(x[8:0]) >= int'(y[14:9]) * 512 + int'(y[8:0])) begin
      big = x; sml = y;
    end else begin
      big = y; sml = x;
    end
    d  = int'(big[14:9]) - int'(sml[14:9]);
    vb = 512 + int'(big[8:0]);
    vs = (d >= 10) ? 0 : (512 + int'(sml[8:0])) / (1 << d);
    r  = (big[15] == sml[15]) ? vb + vs : vb - vs;
    if (r == 0) return 16'h0000;
    e = int'(big[14:9]);
    while (r >= 1024) begin r = r / 2; e = e + 1; end
    while (r < 512) begin r = r * 2; e = e - 1; end
    if (e > 62) return 16'hFFFF;
    if (e < 1) return 16'h0000;
    return {big[15], 6'(e), 9'(r)};
  endfunction

  function automatic logic [15:0] m_dot(int n, logic [3:0][15:0] a, logic [3:0][15:0] b);
    logic [15:0] acc = 16'h0000;
    for (int i = 0; i < n; i++) acc = m_add(acc, m_mul(a[i], b[i]));
    return acc;
  endfunction

  // ---------- drivers (called just after a falling edge) ----------
  task automatic push(int u, logic [15:0] d);
    int t = 0;
    bit ok = 0;
    bit rdy;
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    while (!ok && t < 50) begin
      rdy = in_ready[u];
      @(posedge clk);
      @(negedge clk);
      if (rdy) ok = 1;
      t++;
    end
    in_valid[u] = 1'b0;
    check("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic get_result(int u, output logic [15:0] r, output bit ok);
    int t = 0;
    int got = 0;
    int nb = (OW == 8) ? 2 : 1;
    r = 16'h0000;
    out_ready[u] = 1'b1;
    while (got < nb && t < 60) begin
      if (out_valid[u]) begin
`ifdef DLDOT_BYTE_SERIAL_EN
        r = {r[7:0], out_data[u]};
`else
        r = out_data[u];
`endif
        got++;
      end
      @(posedge clk);
      @(negedge clk);
      t++;
    end
    out_ready[u] = 1'b0;
    ok = (got == nb);
  endtask

  task automatic wait_ov(int u, output bit ok);
    int t = 0;
    while (!out_valid[u] && t < 30) begin
      @(negedge clk);
      t++;
    end
    ok = out_valid[u];
  endtask

  task automatic pulse_clr(int u);
    acc_clr[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_clr[u] = 1'b0;
  endtask

  task automatic send_pairs(int u, int n, logic [3:0][15:0] a, logic [3:0][15:0] b);
    for (int i = 0; i < n; i++) begin
      push(u, a[i]);
      push(u, b[i]);
    end
  endtask

  task automatic run_vec(int u, logic [3:0][15:0] a, logic [3:0][15:0] b, logic [15:0] exp, string name);
    logic [15:0] r;
    bit ok;
    send_pairs(u, vlen_of(u), a, b);
    get_result(u, r, ok);
    check({name, "_handshake"}, 32'(ok), 32'd1);
    check(name, 32'(r), 32'(exp));
  endtask

  typedef struct {
    int               u;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [15:0]      exp;
    string            name;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(int u, string name, logic [15:0] a0, logic [15:0] b0, logic [15:0] a1, logic [15:0] b1,
                         logic [15:0] a2, logic [15:0] b2, logic [15:0] a3, logic [15:0] b3, logic [15:0] exp);
    vec_t v;
    v.u = u; v.name = name; v.exp = exp;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    tbl.push_back(v);
  endtask

  function automatic logic [15:0] rand_op();
    if ($urandom_range(0, 9) == 0) return 16'h0000;
    return {1'($urandom_range(0, 1)), 6'($urandom_range(26, 36)), 9'($urandom_range(0, 511))};
  endfunction

  localparam logic [3:0][15:0] ONES = {16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00};
  localparam logic [3:0][15:0] TWOS = {16'h4000, 16'h4000, 16'h4000, 16'h4000};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [15:0] r;
    logic [OW-1:0] held;
    bit ok;
    logic [3:0][15:0] ra, rb;

    for (int u = 0; u < 3; u++) begin
      acc_clr[u] = 1'b0; in_valid[u] = 1'b0; in_data[u] = 16'h0000; out_ready[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check("reset_out_valid", 32'(out_valid[u]), 32'd0);
      check("reset_in_ready", 32'(in_ready[u]), 32'd1);
      check("reset_out_data", 32'(out_data[u]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // ---------- table-driven vectors ----------
    add_vec(0, "ones_x4",   16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00, 16'h4200);
    add_vec(1, "mul_1p5x2", 16'h3F00, 16'h4000, 0, 0, 0, 0, 0, 0, 16'h4100);
    add_vec(2, "cancel",    16'h3E00, 16'h3E00, 16'hBE00, 16'h3E00, 0, 0, 0, 0, 16'h0000);
    add_vec(0, "sticky_nan", 16'h3E00, 16'h3E00, 16'hFFFF, 16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00, 16'hFFFF);
    add_vec(1, "zero_op",   16'h0000, 16'h4000, 0, 0, 0, 0, 0, 0, 16'h0000);
    add_vec(1, "exp63_op",  16'h3E00, 16'h7E00, 0, 0, 0, 0, 0, 0, 16'hFFFF);
    add_vec(1, "mul_ovf",   16'h6000, 16'h6000, 0, 0, 0, 0, 0, 0, 16'hFFFF);
    add_vec(2, "sub_renorm", 16'h4000, 16'h4000, 16'h3E00, 16'hBE00, 0, 0, 0, 0, 16'h4100);
    foreach (tbl[i]) run_vec(tbl[i].u, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].name);

    // ---------- latency: out_valid two cycles after the last B ----------
    send_pairs(0, 4, ONES, ONES);
    check("lat_k0", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    check("lat_k1", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    check("lat_k2", 32'(out_valid[0]), 32'd1);
    get_result(0, r, ok);
    check("lat_result", 32'(r), 32'h4200);

    // ---------- backpressure, then next vector starts from zero ----------
    send_pairs(0, 4, TWOS, ONES);  // 4 x 2.0 = 8.0
    wait_ov(0, ok);
    check("bp_valid", 32'(ok), 32'd1);
    held = out_data[0];
    check("bp_first", 32'(held), (OW == 8) ? 32'h44 : 32'h4400);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid[0]), 32'd1);
      check("bp_hold_data", 32'(out_data[0]), 32'(held));
      check("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    get_result(0, r, ok);
    check("bp_result", 32'(r), 32'h4400);
    run_vec(0, ONES, ONES, 16'h4200, "bp_next");

    // ---------- acc_clr after two pairs ----------
    send_pairs(0, 2, TWOS, TWOS);
    pulse_clr(0);
    check("clr_in_ready", 32'(in_ready[0]), 32'd1);
    run_vec(0, ONES, ONES, 16'h4200, "clr_mid");

    // ---------- acc_clr after an A only: captured A discarded ----------
    push(0, 16'h4000);
    pulse_clr(0);
    run_vec(0, ONES, ONES, 16'h4200, "clr_after_a");

    // ---------- acc_clr while a result waits ----------
    send_pairs(2, 2, ONES, ONES);
    wait_ov(2, ok);
    check("clr_out_pending", 32'(ok), 32'd1);
    pulse_clr(2);
    check("clr_out_dropped", 32'(out_valid[2]), 32'd0);
    run_vec(2, {16'h0, 16'h0, 16'h3E00, 16'h4000}, ONES, 16'h4100, "clr_out_next");

`ifdef DLDOT_BYTE_SERIAL_EN
    // ---------- acc_clr between the two bytes ----------
    send_pairs(1, 1, {16'h0, 16'h0, 16'h0, 16'h4000}, {16'h0, 16'h0, 16'h0, 16'h3E00});
    wait_ov(1, ok);
    out_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[1] = 1'b0;
    check("byte_low_valid", 32'(out_valid[1]), 32'd1);
    check("byte_low_data", 32'(out_data[1]), 32'h00);
    pulse_clr(1);
    check("byte_clr_dropped", 32'(out_valid[1]), 32'd0);
    run_vec(1, {16'h0, 16'h0, 16'h0, 16'h3F00}, {16'h0, 16'h0, 16'h0, 16'h4000}, 16'h4100, "byte_clr_next");
`endif

    // ---------- asynchronous reset mid-vector ----------
    send_pairs(0, 2, TWOS, TWOS);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(0, ONES, ONES, 16'h4200, "rst_mid_next");

    // ---------- random vectors against the model ----------
    for (int k = 0; k < 24; k++) begin
      int u = k % 3;
      for (int i = 0; i < 4; i++) begin
        ra[i] = rand_op();
        rb[i] = rand_op();
      end
      run_vec(u, ra, rb, m_dot(vlen_of(u), ra, rb), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
